// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver: time-multiplexes four active-low 7-segment codes onto a
// 4-digit common-anode display.
// - One-hot active-low anode selects and a shared active-low segment bus.
// - Codes are snapshotted once per frame, so a digit never changes mid-frame.
// - Each digit slot opens with a blanking window that suppresses ghosting.
// Optional feature: define BLINK_EN to add the 'blink' input, the
// BLINK_FRAMES parameter and a frame-counted blink phase.
module ssd_scan_driver #(
  parameter int DIV          = 100000,
  parameter int BLANK_CYC    = 1000
`ifdef BLINK_EN
  ,
  parameter int BLINK_FRAMES = 64
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef BLINK_EN
  input  logic       blink,
`endif
  input  logic [6:0] C0,
  input  logic [6:0] C1,
  input  logic [6:0] C2,
  input  logic [6:0] C3,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       frame_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  // Scan position and shadow state.
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic          r_primed;
  logic [6:0]    r_shadow [4];

  // Registered outputs.
  logic [3:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_ft;

  logic          w_wrap;
  logic          w_load;
  logic          w_blank;
  logic          w_off;
  logic [3:0]    w_an_nxt;
  logic [6:0]    w_seg_nxt;

  assign w_wrap = (r_cnt == CNT_MAX);
  // The first edge after reset primes the shadow; afterwards the shadow only
  // reloads on the last cycle of digit 3, i.e. exactly at frame boundaries.
  assign w_load = !r_primed || (w_wrap && (r_idx == 2'd3));

  // Blanking window at the start of each slot (absent when BLANK_CYC is 0).
  generate
    if (BLANK_CYC == 0) begin : g_no_blank
      assign w_blank = 1'b0;
    end else begin : g_blank
      assign w_blank = (r_cnt < CW'(BLANK_CYC));
    end
  endgenerate

`ifdef BLINK_EN
  // Frames begun in the current blink phase. The prime load opens frame 0,
  // so the phase flips at the start of frame BLINK_FRAMES, 2*BLINK_FRAMES...
  localparam int FW = $clog2(BLINK_FRAMES + 1);
  logic [FW-1:0] r_frm;
  logic          r_phase;

  // Blink phase advances on the load edge itself so whole frames are masked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frm   <= '0;
      r_phase <= 1'b0;
    end else if (w_load) begin
      if (r_frm == FW'(BLINK_FRAMES)) begin
        r_frm   <= FW'(1);
        r_phase <= ~r_phase;
      end else begin
        r_frm   <= r_frm + FW'(1);
      end
    end
  end

  assign w_off = w_blank || (blink && r_phase);
`else
  assign w_off = w_blank;
`endif

  // Slot counter and digit index; idx advances when the slot counter wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_idx    <= 2'd0;
      r_primed <= 1'b0;
    end else begin
      r_primed <= 1'b1;
      if (w_wrap) begin
        r_cnt <= '0;
        r_idx <= r_idx + 2'd1;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // Shadow codes: all four digits captured together on a load edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) r_shadow[i] <= 7'h7F;
    end else if (w_load) begin
      r_shadow[0] <= C0;
      r_shadow[1] <= C1;
      r_shadow[2] <= C2;
      r_shadow[3] <= C3;
    end
  end

  // Next output value, derived from the present scan position and shadow;
  // anode and segment come from the same idx so they always switch together.
  always_comb begin
    w_an_nxt  = 4'hF;
    w_seg_nxt = 7'h7F;
    if (!w_off) begin
      w_an_nxt  = ~(4'b0001 << r_idx);
      w_seg_nxt = r_shadow[r_idx];
    end
  end

  // Output registers; asynchronous reset blanks the display immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an  <= 4'hF;
      r_seg <= 7'h7F;
      r_ft  <= 1'b0;
    end else begin
      r_an  <= w_an_nxt;
      r_seg <= w_seg_nxt;
      r_ft  <= w_load;
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign frame_tick = r_ft;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Bench for ssd_scan_driver: three instances (DIV/BLANK_CYC = 8/2, 4/0, 2/1)
// share clock, reset and codes. Expected outputs come from a closed-form
// model of the absolute edge number since reset release.
module tb_ssd_scan_driver;

  // Handshake: the driver pushes one expected word per DUT before every
  // rising edge; the monitor pops one word per DUT 1 time unit after that
  // edge and compares. Each word is {frame_tick, an[3:0], seg[6:0]}.

  localparam int NDUT = 3;
  localparam int DIV_A = 8, BLANK_A = 2;
  localparam int DIV_B = 4, BLANK_B = 0;
  localparam int DIV_C = 2, BLANK_C = 1;

  int div_t   [NDUT] = '{DIV_A, DIV_B, DIV_C};
  int blank_t [NDUT] = '{BLANK_A, BLANK_B, BLANK_C};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] c_in [4];
  logic [3:0] an_w  [NDUT];
  logic [6:0] seg_w [NDUT];
  logic       ft_w  [NDUT];
`ifdef BLINK_EN
  logic       blink = 1'b0;
`endif

  logic [11:0] exp_q [NDUT][$];
  logic [27:0] sh    [NDUT];
  int          n_edge;
  int          n_checks;
  int          n_fail;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  ssd_scan_driver #(.DIV(DIV_A), .BLANK_CYC(BLANK_A)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
`ifdef BLINK_EN
    .blink(blink),
`endif
    .C0(c_in[0]), .C1(c_in[1]), .C2(c_in[2]), .C3(c_in[3]),
    .an(an_w[0]), .seg(seg_w[0]), .frame_tick(ft_w[0])
  );

  ssd_scan_driver #(.DIV(DIV_B), .BLANK_CYC(BLANK_B)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
`ifdef BLINK_EN
    .blink(blink),
`endif
    .C0(c_in[0]), .C1(c_in[1]), .C2(c_in[2]), .C3(c_in[3]),
    .an(an_w[1]), .seg(seg_w[1]), .frame_tick(ft_w[1])
  );

  ssd_scan_driver #(.DIV(DIV_C), .BLANK_CYC(BLANK_C)) u_dut_c (
    .clk(clk), .rst_n(rst_n),
`ifdef BLINK_EN
    .blink(blink),
`endif
    .C0(c_in[0]), .C1(c_in[1]), .C2(c_in[2]), .C3(c_in[3]),
    .an(an_w[2]), .seg(seg_w[2]), .frame_tick(ft_w[2])
  );

  // ---------------- reference model ----------------
  // Output after edge n (n = 1 is the first edge after release): that edge
  // sees the scan position reached after n-1 edges and the shadow captured
  // at the most recent load edge strictly before n.
  function automatic logic [11:0] model_out(int n, int div, int blank, logic [27:0] shadow);
    int         pos   = n - 1;
    int         cyc   = pos % div;
    int         digit = (pos / div) % 4;
    logic       ft    = (n == 1) || (n % (4 * div) == 0);
    logic [3:0] a     = 4'hF;
    logic [6:0] s     = 7'h7F;
    if (cyc >= blank) begin
      a = 4'b1111 ^ (4'b0001 << digit);
      s = shadow[digit*7 +: 7];
    end
    return {ft, a, s};
  endfunction

  function automatic logic is_load(int n, int div);
    return (n == 1) || (n % (4 * div) == 0);
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic check(string name, logic [11:0] act, logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got ft=%b an=%b seg=%h, expected ft=%b an=%b seg=%h",
               name, $time, act[11], act[10:7], act[6:0], exp[11], exp[10:7], exp[6:0]);
    end
  endtask

  task automatic check_reset(string tag);
    for (int d = 0; d < NDUT; d++)
      check($sformatf("%s_dut%0d", tag, d), {ft_w[d], an_w[d], seg_w[d]}, {1'b0, 4'hF, 7'h7F});
  endtask

  task automatic model_restart();
    n_edge = 0;
    for (int d = 0; d < NDUT; d++) sh[d] = {4{7'h7F}};
  endtask

  // Called at a falling edge: predict every DUT for the coming rising edge,
  // update the model shadows, then wait for the next falling edge.
  task automatic step(bit rnd);
    if (rnd && $urandom_range(0, 11) == 0)
      c_in[$urandom_range(0, 3)] = 7'($urandom_range(0, 127));
    n_edge++;
    for (int d = 0; d < NDUT; d++) begin
      exp_q[d].push_back(model_out(n_edge, div_t[d], blank_t[d], sh[d]));
      if (is_load(n_edge, div_t[d])) sh[d] = {c_in[3], c_in[2], c_in[1], c_in[0]};
    end
    @(negedge clk);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [11:0] e;
    forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < NDUT; d++) begin
        if (exp_q[d].size() > 0) begin
          e = exp_q[d].pop_front();
          check($sformatf("scan_dut%0d_e%0d", d, n_edge), {ft_w[d], an_w[d], seg_w[d]}, e);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    c_in[0] = 7'h40; c_in[1] = 7'h79; c_in[2] = 7'h24; c_in[3] = 7'h30;
    model_restart();

    // Reset held for five cycles: outputs blank, no frame_tick.
    repeat (5) begin
      @(negedge clk);
      check_reset("reset_hold");
    end

    // Release and scan with fixed codes; C0 changes during slot 2 of frame 1,
    // which must only show from frame 2's slot 0 onward.
    rst_n = 1'b1;
    while (n_edge < 4 * 32 + 8) begin
      if (n_edge == 48) c_in[0] = 7'h12;
      step(1'b0);
    end

    // Randomised code changes at random moments.
    repeat (400) step(1'b1);

    // Asynchronous reset part-way through slot 2 (cnt=5) of the 8/2 instance.
    while (n_edge % 32 != 21) step(1'b1);
    #2 rst_n = 1'b0;
    #1 check_reset("reset_async");
    for (int d = 0; d < NDUT; d++)
      if (exp_q[d].size() != 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL queue_at_reset dut%0d: %0d entries left, expected 0", d, exp_q[d].size());
      end
    repeat (3) begin
      @(negedge clk);
      check_reset("reset_mid");
    end

    // Restart: scanning must begin again at digit 0 with a fresh prime load.
    rst_n = 1'b1;
    model_restart();
    repeat (300) step(1'b1);

    // Drain and confirm every expectation was consumed.
    @(posedge clk);
    #3;
    for (int d = 0; d < NDUT; d++) begin
      n_checks++;
      if (exp_q[d].size() != 0) begin
        n_fail++;
        $display("FAIL drain dut%0d: %0d entries left, expected 0", d, exp_q[d].size());
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion before 200000");
    $fatal(1, "timeout");
  end

endmodule
